// File: rtl/fp_wire.sv
// Shared types for fp_scoreboard: queued entry layout, FSM encoding and canonical qNaN patterns.
// Result fields are carried at 64 bits, so the scoreboard supports XLEN up to 64.
package fp_wire;

   localparam int ENT_XLEN = 64;

   typedef struct packed {
      logic [ENT_XLEN-1:0] result;
      logic [4:0]          flags;
      logic [1:0]          fmt;
      logic                nan_ok;
      logic                last;
   } fp_entry_t;

   localparam int ENTRY_W = $bits(fp_entry_t);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_PASS  = 3'd3;
   localparam logic [2:0] S_FAIL  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_RUN   = S_RUN,
      ST_DRAIN = S_DRAIN,
      ST_PASS  = S_PASS,
      ST_FAIL  = S_FAIL
   } fp_state_e;

   // The kept diff bits (exponent plus quiet bit) happen to equal the NaN patterns themselves.
   localparam logic [63:0] QNAN_S      = 64'h0000_0000_7FC0_0000;
   localparam logic [63:0] QNAN_D      = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] QNAN_MASK_S = 64'h0000_0000_7FC0_0000;
   localparam logic [63:0] QNAN_MASK_D = 64'h7FF8_0000_0000_0000;

   function automatic logic [63:0] qnan_masked_diff(
      input logic [63:0] raw,
      input logic [63:0] dut,
      input logic [1:0]  fmt,
      input logic        nan_ok
   );
      logic [63:0] res;
      if (nan_ok && (fmt == 2'd0) && (dut == QNAN_S)) begin
         res = raw & QNAN_MASK_S;
      end else if (nan_ok && (fmt != 2'd0) && (dut == QNAN_D)) begin
         res = raw & QNAN_MASK_D;
      end else begin
         res = raw;
      end
      return res;
   endfunction

endpackage

// File: rtl/fp_scoreboard_fifo.sv
// Strict-order FIFO of expected entries with same-cycle push/pop and an empty-bypass read path.
module fp_scoreboard_fifo
   import fp_wire::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = ENTRY_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;

   // Head of queue; when empty the incoming entry is presented directly so a same-cycle pop sees it.
   always_comb begin
      if (empty_q) begin
         dout = din;
      end else begin
         dout = mem_q[rd_ptr_q];
      end
   end

   // Pointer, storage and occupancy updates; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Entry storage; slots are only read after being written, so no reset is needed.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/fp_scoreboard.sv
// Scoreboard comparing fp_unit results against queued reference entries, with sticky pass/fail.
// Optional NaN-relaxed compare is enabled by defining FP_SCOREBOARD_NAN_MASK_EN.
module fp_scoreboard
   import fp_wire::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     exp_valid,
   input  logic [XLEN-1:0]          exp_result,
   input  logic [4:0]               exp_flags,
   input  logic [1:0]               exp_fmt,
   input  logic                     exp_nan_ok,
   input  logic                     exp_last,
   input  logic                     dut_ready,
   input  logic [XLEN-1:0]          dut_result,
   input  logic [4:0]               dut_flags,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     done,
   output logic                     fail,
   output logic                     err_ovf,
   output logic                     err_udf,
   output logic [31:0]              pass_cnt,
   output logic [XLEN-1:0]          fail_ref,
   output logic [XLEN-1:0]          fail_calc,
   output logic [XLEN-1:0]          fail_diff,
   output logic [4:0]               fail_fdiff
);

   fp_entry_t         push_ent_s, head_s;
   logic [ENTRY_W-1:0] head_bits_s;
   logic              fifo_full_s, fifo_empty_s;
   logic              push_req_s, pop_req_s, ovf_s, udf_s;
   logic              fifo_push_s, fifo_pop_s, hit_s, miss_s;
   logic [63:0]       dut_ext_s, raw_diff_s, diff64_s;
   logic [XLEN-1:0]   diff_s;
   logic [4:0]        fdiff_s;
   logic              match_s;

   logic [2:0]        state_q, state_d;
   logic [31:0]       pass_cnt_q, pass_cnt_d;
   logic              done_q, done_d, fail_q, fail_d;
   logic              err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
   logic [XLEN-1:0]   fail_ref_q, fail_ref_d, fail_calc_q, fail_calc_d;
   logic [XLEN-1:0]   fail_diff_q, fail_diff_d;
   logic [4:0]        fail_fdiff_q, fail_fdiff_d;

   // Pack the incoming reference into the 64-bit-wide entry layout.
   always_comb begin
      push_ent_s                    = '0;
      push_ent_s.result[XLEN-1:0]   = exp_result;
      push_ent_s.flags              = exp_flags;
      push_ent_s.fmt                = exp_fmt;
      push_ent_s.nan_ok             = exp_nan_ok;
      push_ent_s.last               = exp_last;
   end

   fp_scoreboard_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push_s),
      .pop   (fifo_pop_s),
      .din   (push_ent_s),
      .dout  (head_bits_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (count)
   );

   assign head_s = fp_entry_t'(head_bits_s);

   // Result/flag comparison of the DUT output against the queue head.
   always_comb begin
      dut_ext_s             = '0;
      dut_ext_s[XLEN-1:0]   = dut_result;
      raw_diff_s            = dut_ext_s ^ head_s.result;
`ifdef FP_SCOREBOARD_NAN_MASK_EN
      diff64_s = qnan_masked_diff(raw_diff_s, dut_ext_s, head_s.fmt, head_s.nan_ok);
`else
      diff64_s = raw_diff_s;
`endif
      diff_s  = diff64_s[XLEN-1:0];
      fdiff_s = dut_flags ^ head_s.flags;
      match_s = (diff_s == '0) && (fdiff_s == 5'd0);
   end

`ifndef FP_SCOREBOARD_NAN_MASK_EN
   logic unused_nan_s;
   assign unused_nan_s = ^{head_s.fmt, head_s.nan_ok};
`endif

   // Qualify pushes/pops by phase; an overflowing push is dropped and an underflowing pop skips compare.
   always_comb begin
      push_req_s  = exp_valid && ((state_q == S_IDLE) || (state_q == S_RUN));
      pop_req_s   = dut_ready && ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DRAIN));
      ovf_s       = push_req_s && fifo_full_s && !pop_req_s;
      udf_s       = pop_req_s && fifo_empty_s && !push_req_s;
      fifo_push_s = push_req_s && !ovf_s;
      fifo_pop_s  = pop_req_s && !udf_s;
      hit_s       = fifo_pop_s && match_s;
      miss_s      = fifo_pop_s && !match_s;
   end

   // Run-phase FSM; PASS and FAIL are terminal until reset.
   always_comb begin
      if (ovf_s || udf_s || miss_s) begin
         state_d = S_FAIL;
      end else if (hit_s && head_s.last) begin
         state_d = S_PASS;
      end else begin
         case (state_q)
            S_IDLE, S_RUN: begin
               if (fifo_push_s && exp_last) begin
                  state_d = S_DRAIN;
               end else if (push_req_s) begin
                  state_d = S_RUN;
               end else begin
                  state_d = state_q;
               end
            end
            S_DRAIN: state_d = S_DRAIN;
            S_PASS:  state_d = S_PASS;
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_FAIL;
         endcase
      end
   end

   // Sticky status, saturating pass counter and first-mismatch capture.
   always_comb begin
      if (hit_s && (pass_cnt_q != 32'hFFFF_FFFF)) begin
         pass_cnt_d = pass_cnt_q + 32'd1;
      end else begin
         pass_cnt_d = pass_cnt_q;
      end
      done_d    = done_q | (hit_s & head_s.last);
      fail_d    = fail_q | ovf_s | udf_s | miss_s;
      err_ovf_d = err_ovf_q | ovf_s;
      err_udf_d = err_udf_q | udf_s;
      if (miss_s && !fail_q) begin
         fail_ref_d   = head_s.result[XLEN-1:0];
         fail_calc_d  = dut_result;
         fail_diff_d  = diff_s;
         fail_fdiff_d = fdiff_s;
      end else begin
         fail_ref_d   = fail_ref_q;
         fail_calc_d  = fail_calc_q;
         fail_diff_d  = fail_diff_q;
         fail_fdiff_d = fail_fdiff_q;
      end
   end

   // Register bank with synchronous active-low reset; reset cycle performs no compare.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         pass_cnt_q   <= 32'd0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_udf_q    <= 1'b0;
         fail_ref_q   <= '0;
         fail_calc_q  <= '0;
         fail_diff_q  <= '0;
         fail_fdiff_q <= 5'd0;
      end else begin
         state_q      <= state_d;
         pass_cnt_q   <= pass_cnt_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         err_ovf_q    <= err_ovf_d;
         err_udf_q    <= err_udf_d;
         fail_ref_q   <= fail_ref_d;
         fail_calc_q  <= fail_calc_d;
         fail_diff_q  <= fail_diff_d;
         fail_fdiff_q <= fail_fdiff_d;
      end
   end

   assign full       = fifo_full_s;
   assign done       = done_q;
   assign fail       = fail_q;
   assign err_ovf    = err_ovf_q;
   assign err_udf    = err_udf_q;
   assign pass_cnt   = pass_cnt_q;
   assign fail_ref   = fail_ref_q;
   assign fail_calc  = fail_calc_q;
   assign fail_diff  = fail_diff_q;
   assign fail_fdiff = fail_fdiff_q;

endmodule

// File: tb/tb_fp_scoreboard.sv
// Randomized plus directed bench for fp_scoreboard: a queue-based reference model predicts every
// cycle's outputs into an expectation queue that a negedge monitor pops and compares.
module tb_fp_scoreboard;
   import fp_wire::*;

   localparam int XLEN  = 64;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            exp_valid = 1'b0;
   logic [XLEN-1:0] exp_result = '0;
   logic [4:0]      exp_flags = '0;
   logic [1:0]      exp_fmt = '0;
   logic            exp_nan_ok = 1'b0;
   logic            exp_last = 1'b0;
   logic            dut_ready = 1'b0;
   logic [XLEN-1:0] dut_result = '0;
   logic [4:0]      dut_flags = '0;
   logic            full, done, fail, err_ovf, err_udf;
   logic [CW-1:0]   count;
   logic [31:0]     pass_cnt;
   logic [XLEN-1:0] fail_ref, fail_calc, fail_diff;
   logic [4:0]      fail_fdiff;

   fp_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .exp_valid(exp_valid), .exp_result(exp_result), .exp_flags(exp_flags),
      .exp_fmt(exp_fmt), .exp_nan_ok(exp_nan_ok), .exp_last(exp_last),
      .dut_ready(dut_ready), .dut_result(dut_result), .dut_flags(dut_flags),
      .full(full), .count(count), .done(done), .fail(fail),
      .err_ovf(err_ovf), .err_udf(err_udf), .pass_cnt(pass_cnt),
      .fail_ref(fail_ref), .fail_calc(fail_calc), .fail_diff(fail_diff), .fail_fdiff(fail_fdiff)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  flg;
      logic [1:0]  fmt;
      bit          nok;
      bit          last;
   } ment_t;

   typedef struct {
      int          cnt;
      bit          full, done, fail, ovf, udf;
      logic [31:0] pc;
      logic [63:0] cref, calc, diff;
      logic [4:0]  fdiff;
   } resp_t;

   ment_t       mq[$];
   resp_t       expq[$];
   bit          m_done, m_fail, m_ovf, m_udf, m_last_seen;
   logic [31:0] m_pc;
   logic [63:0] m_ref, m_calc, m_diff;
   logic [4:0]  m_fdiff;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [63:0] ref_diff(input logic [63:0] d, input logic [63:0] e,
                                            input logic [1:0] fmt, input bit nok);
      logic [63:0] x;
      x = d ^ e;
`ifdef FP_SCOREBOARD_NAN_MASK_EN
      if (nok && fmt == 2'd0 && d == 64'h0000_0000_7FC0_0000) begin
         for (int b = 0; b < 64; b++) if (b < 22 || b > 30) x[b] = 1'b0;
      end else if (nok && fmt != 2'd0 && d == 64'h7FF8_0000_0000_0000) begin
         for (int b = 0; b < 64; b++) if (b < 51 || b > 62) x[b] = 1'b0;
      end
`endif
      return x;
   endfunction

   // Reference model: advance one clock given this cycle's inputs, queue the predicted outputs.
   task automatic model(input bit r, input bit ev, input ment_t e, input bit rdy,
                        input logic [63:0] dres, input logic [4:0] dflg);
      bit acc, ovf, udf;
      ment_t h;
      logic [63:0] d;
      logic [4:0] fd;
      resp_t rp;
      if (!r) begin
         mq.delete();
         m_done = 0; m_fail = 0; m_ovf = 0; m_udf = 0; m_last_seen = 0;
         m_pc = 0; m_ref = 0; m_calc = 0; m_diff = 0; m_fdiff = 0;
      end else if (!(m_done || m_fail)) begin
         acc = ev && !m_last_seen;
         ovf = acc && mq.size() == DEPTH && !rdy;
         udf = rdy && mq.size() == 0 && !acc;
         if (acc && !ovf) begin
            mq.push_back(e);
            if (e.last) m_last_seen = 1;
         end
         if (ovf) begin m_ovf = 1; m_fail = 1; end
         if (udf) begin m_udf = 1; m_fail = 1; end
         if (rdy && !udf) begin
            h  = mq.pop_front();
            d  = ref_diff(dres, h.res, h.fmt, h.nok);
            fd = dflg ^ h.flg;
            if (d == 0 && fd == 0) begin
               if (m_pc != 32'hFFFF_FFFF) m_pc++;
               if (h.last) m_done = 1;
            end else begin
               m_ref = h.res; m_calc = dres; m_diff = d; m_fdiff = fd;
               m_fail = 1;
            end
         end
      end
      rp.cnt = mq.size(); rp.full = (mq.size() == DEPTH);
      rp.done = m_done; rp.fail = m_fail; rp.ovf = m_ovf; rp.udf = m_udf; rp.pc = m_pc;
      rp.cref = m_ref; rp.calc = m_calc; rp.diff = m_diff; rp.fdiff = m_fdiff;
      expq.push_back(rp);
   endtask

   task automatic step(input bit r, input bit ev, input logic [63:0] res, input logic [4:0] flg,
                       input logic [1:0] fmt, input bit nok, input bit lst, input bit rdy,
                       input logic [63:0] dres, input logic [4:0] dflg);
      ment_t e;
      @(negedge clock); #1;
      reset = r; exp_valid = ev; exp_result = res; exp_flags = flg; exp_fmt = fmt;
      exp_nan_ok = nok; exp_last = lst; dut_ready = rdy; dut_result = dres; dut_flags = dflg;
      e.res = res; e.flg = flg; e.fmt = fmt; e.nok = nok; e.last = lst;
      model(r, ev, e, rdy, dres, dflg);
   endtask

   task automatic rst_t();  step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic idle_t(); step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic push_t(input logic [63:0] v, input logic [4:0] f, input logic [1:0] fm,
                         input bit nok, input bit lst);
      step(1, 1, v, f, fm, nok, lst, 0, 0, 0);
   endtask
   task automatic pop_t(input logic [63:0] v, input logic [4:0] f);
      step(1, 0, 0, 0, 0, 0, 0, 1, v, f);
   endtask
   task automatic after_edge(); @(posedge clock); #1; endtask

   // Monitor: every cycle the DUT presents status, compare it with the oldest prediction.
   resp_t mr;
   always @(negedge clock) begin
      if (expq.size() > 0) begin
         mr = expq.pop_front();
         chk("count", 64'(count), 64'(mr.cnt));
         chk("full", 64'(full), 64'(mr.full));
         chk("done", 64'(done), 64'(mr.done));
         chk("fail", 64'(fail), 64'(mr.fail));
         chk("err_ovf", 64'(err_ovf), 64'(mr.ovf));
         chk("err_udf", 64'(err_udf), 64'(mr.udf));
         chk("pass_cnt", 64'(pass_cnt), 64'(mr.pc));
         chk("fail_ref", fail_ref, mr.cref);
         chk("fail_calc", fail_calc, mr.calc);
         chk("fail_diff", fail_diff, mr.diff);
         chk("fail_fdiff", 64'(fail_fdiff), 64'(mr.fdiff));
      end
   end

   logic [63:0] r_res, r_dres, canon;
   logic [4:0]  r_flg, r_dflg;
   logic [1:0]  r_fmt;
   bit          r_ev, r_nok, r_lst, r_rdy;
   int          pushes, last_at;

   initial begin
      rst_t(); rst_t();

      // three matching entries, last carried by the third
      push_t(64'h1111, 5'h01, 2'd1, 0, 0);
      push_t(64'h2222, 5'h02, 2'd1, 0, 0);
      push_t(64'h3333, 5'h03, 2'd1, 0, 1);
      pop_t(64'h1111, 5'h01);
      pop_t(64'h2222, 5'h02);
      pop_t(64'h3333, 5'h03);
      after_edge();
      chk("pass3_done", 64'(done), 64'd1);
      chk("pass3_cnt", 64'(pass_cnt), 64'd3);
      chk("pass3_fail", 64'(fail), 64'd0);

      // single-LSB mismatch freezes captures, later pops ignored
      rst_t();
      push_t(64'h3FF0_0000_0000_0000, 5'h0, 2'd1, 0, 0);
      push_t(64'h4000_0000_0000_0000, 5'h0, 2'd1, 0, 0);
      pop_t(64'h3FF0_0000_0000_0001, 5'h0);
      after_edge();
      chk("mis_fail", 64'(fail), 64'd1);
      chk("mis_diff", fail_diff, 64'h1);
      pop_t(64'hDEAD, 5'h1F);
      after_edge();
      chk("mis_hold", fail_diff, 64'h1);
      chk("mis_cnt", 64'(count), 64'd1);

      // canonical single qNaN against a NaN reference with relaxed compare
      rst_t();
      push_t(64'h0000_0000_FFC0_0001, 5'h0, 2'd0, 1, 1);
      pop_t(64'h0000_0000_7FC0_0000, 5'h0);
      after_edge();
`ifdef FP_SCOREBOARD_NAN_MASK_EN
      chk("nan_done", 64'(done), 64'd1);
      chk("nan_fail", 64'(fail), 64'd0);
`else
      chk("nan_fail", 64'(fail), 64'd1);
      chk("nan_diff", fail_diff, 64'h8000_0001);
`endif

      // fill to DEPTH, push+pop while full, then overflow
      rst_t();
      for (int i = 0; i < DEPTH; i++) push_t(64'(i + 10), 5'h0, 2'd1, 0, 0);
      step(1, 1, 64'd99, 5'h0, 2'd1, 0, 0, 1, 64'd10, 5'h0);
      after_edge();
      chk("full_pp_cnt", 64'(count), 64'(DEPTH));
      chk("full_pp_err", 64'(err_ovf), 64'd0);
      push_t(64'd77, 5'h0, 2'd1, 0, 0);
      after_edge();
      chk("ovf_flag", 64'(err_ovf), 64'd1);
      chk("ovf_fail", 64'(fail), 64'd1);

      // pop while empty
      rst_t();
      pop_t(64'h5, 5'h0);
      after_edge();
      chk("udf_flag", 64'(err_udf), 64'd1);
      chk("udf_fail", 64'(fail), 64'd1);
      chk("udf_pc", 64'(pass_cnt), 64'd0);

      // reset mid-run discards queued entries; then bypass push+pop while empty
      rst_t();
      for (int i = 0; i < 3; i++) push_t(64'(i), 5'h0, 2'd1, 0, 0);
      rst_t();
      after_edge();
      chk("rst_cnt", 64'(count), 64'd0);
      chk("rst_state", 64'(dut.state_q), 64'(S_IDLE));
      chk("rst_fail", 64'(fail), 64'd0);
      step(1, 1, 64'hABCD, 5'h3, 2'd1, 0, 1, 1, 64'hABCD, 5'h3);
      after_edge();
      chk("bypass_done", 64'(done), 64'd1);
      chk("bypass_cnt", 64'(count), 64'd0);

      // randomized runs against the reference model
      for (int run = 0; run < 24; run++) begin
         rst_t();
         pushes  = 0;
         last_at = $urandom_range(2, 9);
         for (int c = 0; c < 40; c++) begin
            r_ev  = ($urandom_range(0, 2) != 0);
            r_fmt = 2'($urandom_range(0, 3));
            r_nok = 1'($urandom_range(0, 1));
            r_flg = 5'($urandom);
            r_res = {$urandom, $urandom};
            canon = (r_fmt == 2'd0) ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;
            if ($urandom_range(0, 4) == 0) r_res = canon ^ ({$urandom, $urandom} & ~canon);
            r_lst = r_ev && (pushes == last_at);
            r_rdy = ($urandom_range(0, 3) != 0) &&
                    (mq.size() > 0 || (r_ev && !m_last_seen) || $urandom_range(0, 30) == 0);
            if (mq.size() > 0) begin
               r_dres = mq[0].res; r_dflg = mq[0].flg;
               canon  = (mq[0].fmt == 2'd0) ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;
            end else begin
               r_dres = r_res; r_dflg = r_flg;
            end
            if ((r_dres & canon) == canon && $urandom_range(0, 1) == 1) r_dres = canon;
            if ($urandom_range(0, 19) == 0) r_dres[$urandom_range(0, 63)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) r_dflg ^= 5'h10;
            if (r_ev) pushes++;
            step(1, r_ev, r_res, r_flg, r_fmt, r_nok, r_lst, r_rdy, r_dres, r_dflg);
         end
      end

      idle_t();
      repeat (3) @(negedge clock);
      n_chk++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL monitor_drain: actual=%0d pending required=0", expq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
